// File: rtl/uart_transmitter.sv
// UART transmit stage: serialises one byte per accepted write into an
// 11-bit frame (start, 8 data LSB first, even parity, stop), with each bit
// held for OVERSAMPLE strobes of the 16x baud enable.
//
// state  | meaning
// IDLE   | line high, waiting for a write
// START  | start bit (0) on the line
// DATA   | data bit shift_reg[0] on the line, bit_idx counts bits sent
// PARITY | even-parity bit on the line
// STOP   | stop bit (1) on the line
module uart_transmitter #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Tx_EN,
  input  logic                 Tx_WR,
  input  logic [DATA_BITS-1:0] Tx_DATA,
  input  logic                 Tx_sample_ENABLE,
  output logic                 Tx_D,
  output logic                 Tx_BUSY
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_n;
  logic [3:0]           tick, tick_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift_reg, shift_reg_n;
  logic                 parity, parity_n;
  logic                 tx_d_n, tx_busy_n;

  // Next-state, datapath and line value; outputs are derived from the
  // next state so they register on the same edge as the state change.
  always_comb begin
    state_n     = state;
    tick_n      = tick;
    bit_idx_n   = bit_idx;
    shift_reg_n = shift_reg;
    parity_n    = parity;

    if (state == IDLE) begin
      // A strobe on the accepting edge is discarded: the counter restarts at 0.
      if (Tx_WR && !Tx_BUSY) begin
        shift_reg_n = Tx_DATA;
        parity_n    = ^Tx_DATA;
        tick_n      = 4'd0;
        bit_idx_n   = 3'd0;
        state_n     = START;
      end
    end else if (Tx_sample_ENABLE) begin
      if (tick == TICK_LAST) begin
        tick_n = 4'd0;
        case (state)
          START:   state_n = DATA;
          DATA: begin
            bit_idx_n   = bit_idx + 3'd1;
            shift_reg_n = shift_reg >> 1;
            if (bit_idx == BIT_LAST) state_n = PARITY;
          end
          PARITY:  state_n = STOP;
          STOP:    state_n = IDLE;
          default: state_n = IDLE;
        endcase
      end else begin
        tick_n = tick + 4'd1;
      end
    end

    // Dropping the enable abandons the frame; data/parity are left as-is.
    if (!Tx_EN) begin
      state_n   = IDLE;
      tick_n    = 4'd0;
      bit_idx_n = 3'd0;
    end

    case (state_n)
      START:   tx_d_n = 1'b0;
      DATA:    tx_d_n = shift_reg_n[0];
      PARITY:  tx_d_n = parity_n;
      default: tx_d_n = 1'b1;
    endcase
    tx_busy_n = (state_n != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tick      <= 4'd0;
      bit_idx   <= 3'd0;
      shift_reg <= '0;
      parity    <= 1'b0;
      Tx_D      <= 1'b1;
      Tx_BUSY   <= 1'b0;
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_reg_n;
      parity    <= parity_n;
      Tx_D      <= tx_d_n;
      Tx_BUSY   <= tx_busy_n;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-level model checked every cycle plus
// directed frames with hand-computed bit patterns and durations.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Tx_EN = 1'b1;
  logic       Tx_WR = 1'b0;
  logic [7:0] Tx_DATA = 8'h00;
  logic       Tx_sample_ENABLE = 1'b0;
  logic       Tx_D;
  logic       Tx_BUSY;

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;

  uart_transmitter #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .Tx_EN            (Tx_EN),
    .Tx_WR            (Tx_WR),
    .Tx_DATA          (Tx_DATA),
    .Tx_sample_ENABLE (Tx_sample_ENABLE),
    .Tx_D             (Tx_D),
    .Tx_BUSY          (Tx_BUSY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: a frame is 11 bits, the line shows bit (strobes/16).
  bit        busy_m  = 1'b0;
  int        cnt_m   = 0;
  bit [10:0] frame_m = '1;

  // Model update from the same inputs the DUT sees at each rising edge.
  always @(posedge clk) begin
    if (reset || !Tx_EN) begin
      busy_m = 1'b0;
      cnt_m  = 0;
    end else if (!busy_m) begin
      if (Tx_WR) begin
        busy_m  = 1'b1;
        cnt_m   = 0;
        frame_m = {1'b1, ^Tx_DATA, Tx_DATA, 1'b0};
      end
    end else if (Tx_sample_ENABLE) begin
      cnt_m++;
      if (cnt_m == 176) busy_m = 1'b0;
    end
  end

  // Per-cycle comparison of the DUT line and busy flag against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_busy", {31'd0, Tx_BUSY}, {31'd0, busy_m});
      chk("tx_d", {31'd0, Tx_D}, {31'd0, busy_m ? frame_m[cnt_m / 16] : 1'b1});
    end
  end

  task automatic idle_strobes(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      Tx_sample_ENABLE = (i % period == period - 1);
      @(negedge clk);
    end
    Tx_sample_ENABLE = 1'b0;
  endtask

  // Sends one frame from a negedge. wr_mid: clock index of a stray write
  // (0xA3) while busy; wr_end: stray write on the final stop strobe;
  // abort_kind 1 = drop Tx_EN, 2 = 2-clock reset, at strobe count abort_at.
  task automatic send(input string nm, input logic [7:0] data, input int period,
                      input logic [10:0] exp, input int wr_mid, input bit wr_end,
                      input int abort_at, input int abort_kind);
    int        strobes = 0;
    int        busy_clks = 0;
    int        i = 0;
    logic [10:0] got = '1;
    bit [10:0] rec = '0;
    bit        done = 1'b0;
    Tx_WR = 1'b1;
    Tx_DATA = data;
    Tx_sample_ENABLE = 1'b0;
    @(negedge clk);
    Tx_WR = 1'b0;
    while (!done) begin
      if (Tx_BUSY) busy_clks++;
      if (strobes < 176 && strobes % 16 == 8 && !rec[strobes / 16]) begin
        got[strobes / 16] = Tx_D;
        rec[strobes / 16] = 1'b1;
      end
      if (strobes == 176) begin
        done = 1'b1;
      end else if (abort_kind != 0 && strobes == abort_at) begin
        Tx_sample_ENABLE = 1'b0;
        if (abort_kind == 1) begin
          Tx_EN = 1'b0;
          Tx_WR = 1'b1;
          @(negedge clk);
          Tx_EN = 1'b0;
          Tx_WR = 1'b0;
          chk({nm, "_abort_d"}, {31'd0, Tx_D}, 32'd1);
          chk({nm, "_abort_busy"}, {31'd0, Tx_BUSY}, 32'd0);
          Tx_EN = 1'b1;
        end else begin
          reset = 1'b1;
          Tx_WR = 1'b1;
          @(negedge clk);
          @(negedge clk);
          reset = 1'b0;
          Tx_WR = 1'b0;
          chk({nm, "_reset_d"}, {31'd0, Tx_D}, 32'd1);
          chk({nm, "_reset_busy"}, {31'd0, Tx_BUSY}, 32'd0);
        end
        return;
      end else begin
        Tx_sample_ENABLE = (i % period == period - 1);
        Tx_WR = (i == wr_mid) || (wr_end && Tx_sample_ENABLE && strobes == 175);
        if (i == wr_mid) Tx_DATA = 8'hA3;
        @(negedge clk);
        if (Tx_sample_ENABLE) strobes++;
        i++;
      end
    end
    Tx_sample_ENABLE = 1'b0;
    Tx_WR = 1'b0;
    chk({nm, "_bits"}, {21'd0, got}, {21'd0, exp});
    if (busy_clks < 176 * period - 3 || busy_clks > 176 * period + 3)
      chk({nm, "_busy_len"}, busy_clks, 176 * period);
    else
      vectors++;
    chk({nm, "_end_busy"}, {31'd0, Tx_BUSY}, 32'd0);
    chk({nm, "_end_d"}, {31'd0, Tx_D}, 32'd1);
  endtask

  // {stop, parity, data[7:0], start}
  localparam logic [10:0] F55 = 11'b1_0_01010101_0;
  localparam logic [10:0] F07 = 11'b1_1_00000111_0;
  localparam logic [10:0] F3C = 11'b1_0_00111100_0;
  localparam logic [10:0] FFF = 11'b1_0_11111111_0;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_d", {31'd0, Tx_D}, 32'd1);
    chk("reset_busy", {31'd0, Tx_BUSY}, 32'd0);
    idle_strobes(20, 3);

    send("f55", 8'h55, 4, F55, -1, 1'b0, 0, 0);
    send("f07", 8'h07, 4, F07, -1, 1'b0, 0, 0);

    send("b2b_a", 8'h55, 4, F55, 100, 1'b1, 0, 0);
    send("b2b_b", 8'h3C, 4, F3C, -1, 1'b0, 0, 0);

    send("abort", 8'h55, 4, F55, -1, 1'b0, 72, 1);
    idle_strobes(10, 4);
    send("fff", 8'hFF, 4, FFF, -1, 1'b0, 0, 0);

    send("rst_mid", 8'h07, 3, F07, -1, 1'b0, 50, 2);
    idle_strobes(40, 3);
    chk("post_reset_d", {31'd0, Tx_D}, 32'd1);
    chk("post_reset_busy", {31'd0, Tx_BUSY}, 32'd0);

    send("rate2", 8'h55, 2, F55, -1, 1'b0, 0, 0);
    send("rate7", 8'h55, 7, F55, -1, 1'b0, 0, 0);
    send("rate13", 8'h55, 13, F55, -1, 1'b0, 0, 0);

    idle_strobes(5, 2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit stage of the UART datapath, directly downstream of `baud_controller`. It consumes the 16x-oversampling `sample_ENABLE` strobe and serialises one byte per write into an 11-bit frame: start bit, 8 data bits LSB first, even parity, stop bit. Each bit is held for exactly 16 strobes. The top level instantiates `baud_controller` and wires its `sample_ENABLE` to `Tx_sample_ENABLE`.

## Interface
Parameters:
- `DATA_BITS`, 8, payload width. Only 8 is supported; the parameter exists for documentation.
- `OVERSAMPLE`, 16, number of `Tx_sample_ENABLE` strobes per bit.

Ports:
- `clk` input 1: single system clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `Tx_EN` input 1: transmitter enable. When low, the block sits idle and drops any frame in progress.
- `Tx_WR` input 1: one-cycle write strobe that requests transmission of `Tx_DATA`.
- `Tx_DATA` input 8: byte to send; sampled only on an accepted write.
- `Tx_sample_ENABLE` input 1: one-cycle 16x baud strobe from `baud_controller`.
- `Tx_D` output 1: serial line; idles high.
- `Tx_BUSY` output 1: high while a frame is in flight.

## Operation
- States are IDLE, START, DATA, PARITY and STOP.
  - Tick counter: 4 bits, 0..15.
  - Bit index: 3 bits, 0..7.
  - Shift register: 8 bits.
  - Parity register: 1 bit.
- A write is accepted when `Tx_WR && Tx_EN && !Tx_BUSY` at a rising edge. On that edge:
  - latch `Tx_DATA` into the shift register;
  - set parity = XOR of all 8 data bits (even parity);
  - clear the tick counter and bit index;
  - enter START.
- `Tx_WR` while `Tx_BUSY=1` is ignored. `Tx_DATA` and parity are not updated. There is no queueing.
- In every non-IDLE state, each `Tx_sample_ENABLE` pulse increments the tick counter. When a pulse arrives with tick counter = 15:
  - the counter wraps to 0 and the block moves to the next bit;
  - START goes to DATA;
  - DATA increments the bit index and shifts right; after index 7 it goes to PARITY;
  - PARITY goes to STOP;
  - STOP goes to IDLE.
- `Tx_D` is registered and depends only on the state:
  - IDLE = 1;
  - START = 0;
  - DATA = shift register bit 0;
  - PARITY = parity register;
  - STOP = 1.
- `Tx_BUSY` is registered: 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- `Tx_EN` low at any edge forces the following on that edge:
  - state IDLE, `Tx_D`=1, `Tx_BUSY`=0;
  - tick counter and bit index cleared.
  
  A partial frame is aborted and is not resumed.
- `reset` has priority over `Tx_EN` and `Tx_WR`. It forces the same values as `Tx_EN` low, and also clears the shift and parity registers.
- Strobes received in IDLE are ignored. The tick counter stays at 0.

## Timing
- Reset values:
  - `Tx_D`=1, `Tx_BUSY`=0;
  - state IDLE;
  - all counters and registers 0.
- Write latency:
  - `Tx_BUSY` and `Tx_D`=0 become visible one clock after the accepting edge.
  - Start-bit length is 16 strobes measured from the accepting edge. Phase alignment to the strobe is not required, so the first strobe may come 0 to N-1 clocks after acceptance, where N is the strobe period.
- Each bit lasts exactly 16 strobes. The frame ends 176 strobes after acceptance.
- `Tx_BUSY` falls and `Tx_D` stays 1 on the edge that consumes the 16th STOP strobe.
  - A new `Tx_WR` is accepted on the very next edge, giving back-to-back frames with no idle gap beyond one clock.
- Simultaneous events at one edge:
  - `Tx_WR` with the final STOP strobe: the write is ignored because `Tx_BUSY` is still 1.
  - `Tx_WR` with `Tx_EN`=0: ignored.
  - `Tx_WR` with `reset`: ignored.
- A strobe that coincides with an accepted write does not count toward the start bit.

## Test plan
- Reset behaviour: assert `reset` for 2 clocks mid-frame. Required: `Tx_D`=1 and `Tx_BUSY`=0 one clock later, and they stay so with strobes running and no write.
- Single frame, 0x55: drive `Tx_sample_ENABLE` every 4 clocks, `Tx_EN`=1, pulse `Tx_WR` with 0x55.
  - Required line sequence, 64 clocks per bit (±3 on the start bit): 0, 1,0,1,0,1,0,1,0, parity 0, stop 1.
  - `Tx_BUSY` stays high for 704 ±3 clocks.
- Parity, 0x07: send 0x07. Required: data bits 1,1,1,0,0,0,0,0, then parity 1.
- Back-to-back frames: pulse `Tx_WR` with 0xA3 while busy, then pulse it again one clock after `Tx_BUSY` falls with 0x3C.
  - Required: the first pulse is ignored.
  - The second frame carries 0x3C (parity 0) and starts within 1 clock of `Tx_BUSY` falling.
- Abort: drop `Tx_EN` during DATA bit 3. Required: `Tx_D`=1 and `Tx_BUSY`=0 on the next clock. A subsequent write of 0xFF after `Tx_EN`=1 sends a clean frame with parity 0.
- Strobe rates: repeat the 0x55 frame with the strobe period at 2, 7 and 13 clocks. Required: each bit lasts exactly 16 strobes.
